// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer
// Sequencing controller for a 4-bit universal shift register. It drives the
// register mode selects {s1,s0} so that one request runs a whole transaction:
//   TX: one parallel-load cycle, then WIDTH shifts out.
//   RX: WIDTH shifts in, then a one-cycle done pulse.
// Shifts are spaced DIV clocks apart by a bit-rate divider.
// Optional build macro USR_SEQ_BACK2BACK_EN: when defined, a new request may
// be accepted in the DONE cycle, so consecutive words run with no idle cycle.
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3,
  parameter int DIV   = 1,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             op,
  input  logic             dir,
  input  logic             abort,
  output logic             s1,
  output logic             s0,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0]       MODE_HOLD  = 2'b00;
  localparam logic [1:0]       MODE_RIGHT = 2'b01;
  localparam logic [1:0]       MODE_LEFT  = 2'b10;
  localparam logic [1:0]       MODE_LOAD  = 2'b11;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);

`ifdef USR_SEQ_BACK2BACK_EN
  localparam logic B2B_EN = 1'b1;
`else
  localparam logic B2B_EN = 1'b0;
`endif

  state_t           state_r;
  state_t           state_nxt_s;
  logic             op_r;
  logic             dir_r;
  logic             op_nxt_s;
  logic             dir_nxt_s;
  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_nxt_s;
  logic [1:0]       mode_r;
  logic [1:0]       mode_nxt_s;
  logic             done_r;
  logic             busy_r;
  logic             shift_now_s;
  logic             accept_s;

  // Ready is decoded from state; a request is taken only when abort is low.
  always_comb begin
    start_ready = 1'b0;
    if (state_r == IDLE) begin
      start_ready = 1'b1;
    end else if ((state_r == DONE) && B2B_EN) begin
      start_ready = 1'b1;
    end else begin
      start_ready = 1'b0;
    end
    accept_s    = start_valid && start_ready && !abort;
    shift_now_s = (state_r == SHIFT) && (div_cnt_r == DIV_LAST);
  end

  // Next-state, counters and latched op/dir. A shift issued this cycle counts
  // even if abort arrives with it, since the register has already moved.
  always_comb begin
    state_nxt_s = state_r;
    op_nxt_s    = op_r;
    dir_nxt_s   = dir_r;
    div_nxt_s   = div_cnt_r;
    if (shift_now_s) begin
      bit_nxt_s = bit_cnt_r + CNT_W'(1);
    end else begin
      bit_nxt_s = bit_cnt_r;
    end
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          op_nxt_s    = op;
          dir_nxt_s   = dir;
          div_nxt_s   = {DIV_W{1'b0}};
          bit_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = op ? SHIFT : LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
          div_nxt_s   = {DIV_W{1'b0}};
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (shift_now_s) begin
          div_nxt_s = {DIV_W{1'b0}};
          if (bit_cnt_r == CNT_LAST) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = SHIFT;
          end
        end else begin
          div_nxt_s = div_cnt_r + DIV_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Mode for the coming cycle, looked ahead so that s1/s0 can be registered.
  always_comb begin
    mode_nxt_s = MODE_HOLD;
    case (state_nxt_s)
      LOAD: begin
        mode_nxt_s = MODE_LOAD;
      end
      SHIFT: begin
        if (div_nxt_s == DIV_LAST) begin
          mode_nxt_s = dir_nxt_s ? MODE_LEFT : MODE_RIGHT;
        end else begin
          mode_nxt_s = MODE_HOLD;
        end
      end
      default: begin
        mode_nxt_s = MODE_HOLD;
      end
    endcase
  end

  // State and registered outputs; reset forces hold mode on the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 1'b0;
      dir_r     <= 1'b0;
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      mode_r    <= MODE_HOLD;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      op_r      <= op_nxt_s;
      dir_r     <= dir_nxt_s;
      div_cnt_r <= div_nxt_s;
      bit_cnt_r <= bit_nxt_s;
      mode_r    <= mode_nxt_s;
      done_r    <= (state_nxt_s == DONE);
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  assign s1      = mode_r[1];
  assign s0      = mode_r[0];
  assign busy    = busy_r;
  assign done    = done_r;
  assign bit_cnt = bit_cnt_r;

endmodule
